alarm_sequencer: RTL
====================

Name: alarm_sequencer

Overview:
- Controls the alarm LED flasher and the buzzer.
- Compares current time against a programmed alarm time and runs the ring / snooze / stop sequence.
- Drives the flasher's enable input (flash_en) plus a buzzer enable.
- Sits between the timekeeping counters, the debounced user buttons and the LED flash block.

Parameters:
SNOOZE_SEC, 300, seconds spent in SNOOZE before re-ringing (1..65535)
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze presses are ignored (1..15)
RING_TIMEOUT_SEC, 120, seconds of ringing before auto-stop (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
sec_tick  in  1  one-cycle pulse, once per second
cur_hour  in  5  current hour, binary 0..23
cur_min  in  6  current minute, binary 0..59
alm_hour  in  5  alarm hour, binary 0..23
alm_min  in  6  alarm minute, binary 0..59
arm  in  1  level; alarm armed when 1
snooze_btn  in  1  one-cycle debounced pulse
stop_btn  in  1  one-cycle debounced pulse
flash_en  out  1  enable to the LED flasher
buzzer_en  out  1  buzzer drive
snoozing  out  1  high while in SNOOZE
snooze_left  out  4  remaining snoozes for the current event
state_o  out  2  encoded state (IDLE=0, ARMED=1, RINGING=2, SNOOZE=3)

Behaviour:
- Reset (reset=0, async) forces:
  - state IDLE
  - flash_en=0, buzzer_en=0, snoozing=0
  - snooze_left=MAX_SNOOZE
  - second counter=0, match latch=0
- All outputs are registered; a state change is visible one cycle after the causing input.
- match = (cur_hour==alm_hour)&&(cur_min==alm_min), combinational.
- match_q registers match every cycle.
- fire = match && !match_q && armed-state, i.e. a rising-edge event.
  - Ringing never retriggers within the same matching minute after stop.
  - Changing alm_* into the current minute counts as a rising edge and fires.
- States:
  - IDLE: outputs low. arm=1 -> ARMED.
  - ARMED: fire -> RINGING; snooze_left=MAX_SNOOZE; counter cleared.
  - RINGING: flash_en=1, buzzer_en=1.
    - stop_btn -> ARMED, counter cleared.
    - snooze_btn with snooze_left>0 -> SNOOZE; snooze_left decremented; counter cleared.
    - snooze_btn with snooze_left==0 is ignored.
  - SNOOZE: flash_en=0, buzzer_en=0, snoozing=1.
    - The counter increments on sec_tick.
    - When the counter reaches SNOOZE_SEC (on that tick) -> RINGING, counter cleared.
    - stop_btn -> ARMED.
- arm=0 in any state -> IDLE next cycle, outputs low, counter cleared. This has priority over everything except reset.
- Simultaneous stop_btn and snooze_btn: stop wins.
- Simultaneous button press and the sec_tick that expires snooze: the button is evaluated against the current state (SNOOZE), so stop -> ARMED and snooze is ignored.
- Counter width is $clog2 of the largest count parameter + 1. It saturates and never wraps.
- Reset mid-RINGING or mid-SNOOZE: immediate return to IDLE, flash_en drops asynchronously. The flasher's own reset/enable-low clears its LEDs.
- snooze_left holds its value in ARMED and IDLE until the next fire reloads it.

Optional Feature:
ALARM_SEQ_AUTOSTOP_EN
- Defined:
  - A second counter runs in RINGING on sec_tick.
  - At RING_TIMEOUT_SEC -> ARMED, exactly as for stop_btn.
  - The count resets on every entry to RINGING, so each re-ring after snooze gets a full timeout.
- Undefined: RINGING persists until stop_btn, snooze_btn or arm=0. RING_TIMEOUT_SEC is unused and no timeout logic is generated.

Decomposition:
- Shared package alarm_pkg:
  - state enum alarm_state_t (IDLE, ARMED, RINGING, SNOOZE; 2-bit)
  - HOUR_W=5, MIN_W=6
  - a localparam helper for counter width
- One natural sub-module, alarm_sec_timer:
  - loadable second counter with clear, tick-enable and terminal-count compare
  - instantiated once for snooze, and once more for ring timeout under the macro

Test Plan:
- Reset with arm=1, cur=07:29, alm=07:30; advance cur_min to 30 -> state_o=2, flash_en=1, buzzer_en=1 one cycle after the match edge, snooze_left=3.
- While RINGING, pulse stop_btn with cur still 07:30 -> state_o=1, flash_en=0; no re-fire for the rest of the minute; cur 07:31 then back to 07:30 fires again.
- SNOOZE_SEC=5: ring, snooze_btn -> snoozing=1, snooze_left=2; after exactly 5 sec_ticks state_o=2 again. Repeat until snooze_left=0; a further snooze_btn leaves state RINGING.
- Pulse stop_btn and snooze_btn in the same cycle while RINGING -> state ARMED, snooze_left unchanged.
- Drop arm to 0 in SNOOZE -> IDLE next cycle. Assert reset=0 mid-RINGING -> flash_en=0 with no clock edge needed.
- With ALARM_SEQ_AUTOSTOP_EN and RING_TIMEOUT_SEC=4: ring with no buttons -> ARMED after 4 sec_ticks. Without the macro, still RINGING after 100 ticks.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm sequencer block.
package alarm_pkg;

    // Encoding is visible on state_o: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int LEFT_W = 4;

    // Second-counter width: enough for the larger of the two count limits, plus one bit.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Saturating second counter with clear, tick enable and a terminal-count strobe.
// o_done fires combinationally on the tick that brings the count to i_term, so the
// owner can change state on exactly that tick. o_done does not depend on i_clr,
// which lets the owner derive i_clr from its own next-state logic.
module alarm_sec_timer #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_tick,
    input  logic [W-1:0] i_term,
    output logic         o_done
);

    logic [W-1:0] r_count;
    logic [W:0]   w_inc;

    assign w_inc  = {1'b0, r_count} + {{W{1'b0}}, 1'b1};
    assign o_done = i_tick && (w_inc >= {1'b0, i_term});

    // Count ticks; clear has priority; hold at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_tick && (r_count != {W{1'b1}})) begin
            r_count <= w_inc[W-1:0];
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: compares current time with the alarm time and runs the
// ring / snooze / stop sequence, driving the LED flasher enable and the buzzer.
// Optional macro ALARM_SEQ_AUTOSTOP_EN adds a ring timeout of RING_TIMEOUT_SEC
// seconds that returns to ARMED exactly like a stop press.
//
// Handshake note: there is no valid/ready traffic here; snooze_btn, stop_btn and
// sec_tick are single-cycle strobes sampled on the rising clock edge, and every
// output is a register that reflects the decision made on the previous edge.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC       = 300,
    parameter int MAX_SNOOZE       = 3,
    parameter int RING_TIMEOUT_SEC = 120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [HOUR_W-1:0] alm_hour,
    input  logic [MIN_W-1:0]  alm_min,
    input  logic              arm,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              flash_en,
    output logic              buzzer_en,
    output logic              snoozing,
    output logic [LEFT_W-1:0] snooze_left,
    output logic [1:0]        state_o
);

    localparam int CNT_W = cnt_width(SNOOZE_SEC, RING_TIMEOUT_SEC);

    alarm_state_t      r_state;
    alarm_state_t      w_next;
    logic              r_match_q;
    logic              r_flash_en;
    logic              r_buzzer_en;
    logic              r_snoozing;
    logic [LEFT_W-1:0] r_snooze_left;
    logic [LEFT_W-1:0] w_snooze_left_next;

    logic              w_match;
    logic              w_fire;
    logic              w_snz_done;
    logic              w_snz_clr;
    logic              w_snz_tick;

    // The alarm fires only on the rising edge of the minute match, so a stop
    // inside the matching minute does not re-ring, while moving the alarm time
    // onto the current minute does count as a fresh edge.
    assign w_match = (cur_hour == alm_hour) && (cur_min == alm_min);
    assign w_fire  = w_match && !r_match_q && (r_state == ARMED);

    // Snooze timer runs only in SNOOZE and is cleared whenever SNOOZE is not
    // the next state, so each snooze period starts from zero.
    assign w_snz_tick = sec_tick && (r_state == SNOOZE);
    assign w_snz_clr  = (w_next != SNOOZE);

    alarm_sec_timer #(
        .W (CNT_W)
    ) u_snooze_timer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_snz_clr),
        .i_tick  (w_snz_tick),
        .i_term  (CNT_W'(SNOOZE_SEC)),
        .o_done  (w_snz_done)
    );

`ifdef ALARM_SEQ_AUTOSTOP_EN
    logic w_ring_done;
    logic w_ring_clr;
    logic w_ring_tick;

    // Ring timer restarts on every entry to RINGING, so a re-ring after snooze
    // gets the full timeout.
    assign w_ring_tick = sec_tick && (r_state == RINGING);
    assign w_ring_clr  = (w_next != RINGING);

    alarm_sec_timer #(
        .W (CNT_W)
    ) u_ring_timer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_ring_clr),
        .i_tick  (w_ring_tick),
        .i_term  (CNT_W'(RING_TIMEOUT_SEC)),
        .o_done  (w_ring_done)
    );
`endif

    // Next-state and snooze-budget logic; arm=0 overrides every transition.
    always_comb begin
        w_next             = r_state;
        w_snooze_left_next = r_snooze_left;
        if (!arm) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next = ARMED;
                end
                ARMED: begin
                    if (w_fire) begin
                        w_next             = RINGING;
                        w_snooze_left_next = LEFT_W'(MAX_SNOOZE);
                    end
                end
                RINGING: begin
                    // Stop beats snooze; snooze with no budget left is ignored.
                    if (stop_btn) begin
                        w_next = ARMED;
                    end else if (snooze_btn && (r_snooze_left != '0)) begin
                        w_next             = SNOOZE;
                        w_snooze_left_next = r_snooze_left - 1'b1;
                    end
`ifdef ALARM_SEQ_AUTOSTOP_EN
                    else if (w_ring_done) begin
                        w_next = ARMED;
                    end
`endif
                end
                SNOOZE: begin
                    // A stop on the expiry tick still wins; snooze presses do nothing here.
                    if (stop_btn) begin
                        w_next = ARMED;
                    end else if (w_snz_done) begin
                        w_next = RINGING;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // State, match history and registered outputs; reset drops the enables immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_match_q     <= 1'b0;
            r_flash_en    <= 1'b0;
            r_buzzer_en   <= 1'b0;
            r_snoozing    <= 1'b0;
            r_snooze_left <= LEFT_W'(MAX_SNOOZE);
        end else begin
            r_state       <= w_next;
            r_match_q     <= w_match;
            r_flash_en    <= (w_next == RINGING);
            r_buzzer_en   <= (w_next == RINGING);
            r_snoozing    <= (w_next == SNOOZE);
            r_snooze_left <= w_snooze_left_next;
        end
    end

    assign flash_en    = r_flash_en;
    assign buzzer_en   = r_buzzer_en;
    assign snoozing    = r_snoozing;
    assign snooze_left = r_snooze_left;
    assign state_o     = r_state;

endmodule
